fetch_port: RTL and testbench

- Upstream neighbour of the instruction prefetch buffer; turns the buffer's fetch address into requests on the instruction memory bus.
- Returns word data plus a ready strobe to the buffer.
- Tracks a single outstanding request and discards in-flight responses made stale by a jump or fence.
- Includes a wait watchdog.

---
 rtl/fetch_port.sv | 126 ++++++++++++
 tb/tb_fetch_port.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_port.sv
// Instruction-memory fetch port: turns prefetch fetch requests into single-outstanding
// imem bus requests, drops responses made stale by flushes, and flags stalled waits.
module fetch_port #(
  parameter int unsigned timeout_cycles = 255,
  parameter int unsigned timeout_width  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_flush,
  output logic [31:0] fetch_rdata,
  output logic        fetch_ready,
  output logic        fetch_error,
  output logic        imem_valid,
  output logic        imem_instr,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata
);

  localparam logic [31:0]              NOP     = 32'h0000_0013;
  localparam logic [timeout_width-1:0] TO_VAL  = timeout_width'(timeout_cycles);
  localparam logic [timeout_width-1:0] CNT_MAX = '1;
  localparam bit                       TO_EN   = (timeout_cycles != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    KILL
  } state_e;

  state_e                   state_q, state_d;
  logic                     imem_valid_q, imem_valid_d;
  logic [31:0]              imem_addr_q, imem_addr_d;
  logic [31:0]              pend_addr_q, pend_addr_d;
  logic [timeout_width-1:0] wait_cnt_q, wait_cnt_d;
  logic                     fetch_error_q, fetch_error_d;
  logic [31:0]              tgt_addr;
  logic                     issue;
  logic                     unused_addr_bits;

  assign tgt_addr         = {fetch_addr[31:2], 2'b00};
  assign unused_addr_bits = ^fetch_addr[1:0];

  // A flush in the response cycle means the word belongs to the abandoned stream.
  assign fetch_ready = (state_q == BUSY) & imem_ready & ~fetch_flush;
  assign fetch_rdata = fetch_ready ? imem_rdata : NOP;
  assign fetch_error = fetch_error_q;
  assign imem_valid  = imem_valid_q;
  assign imem_addr   = imem_addr_q;
  assign imem_instr  = 1'b1;

  always_comb begin
    state_d      = state_q;
    imem_valid_d = imem_valid_q;
    imem_addr_d  = imem_addr_q;
    pend_addr_d  = pend_addr_q;
    issue        = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_valid) begin
          issue        = 1'b1;
          imem_addr_d  = tgt_addr;
          imem_valid_d = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (imem_ready) begin
          if (fetch_flush || fetch_valid) begin
            issue        = 1'b1;
            imem_addr_d  = tgt_addr;
            imem_valid_d = 1'b1;
          end else begin
            imem_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end else if (fetch_flush) begin
          // Bus request must stay stable; remember where to go once it retires.
          pend_addr_d = tgt_addr;
          state_d     = KILL;
        end
      end
      KILL: begin
        if (fetch_flush) begin
          pend_addr_d = tgt_addr;
        end
        if (imem_ready) begin
          issue        = 1'b1;
          imem_addr_d  = fetch_flush ? tgt_addr : pend_addr_q;
          imem_valid_d = 1'b1;
          state_d      = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (issue || imem_ready) begin
      wait_cnt_d = '0;
    end else if (state_q != IDLE && wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    fetch_error_d = fetch_error_q | (TO_EN && (wait_cnt_d == TO_VAL));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      imem_valid_q  <= 1'b0;
      imem_addr_q   <= '0;
      pend_addr_q   <= '0;
      wait_cnt_q    <= '0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_valid_q  <= imem_valid_d;
      imem_addr_q   <= imem_addr_d;
      pend_addr_q   <= pend_addr_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_error_q <= fetch_error_d;
    end
  end

endmodule

// File: tb/tb_fetch_port.sv
// Bench for fetch_port: request-level reference model of the bus and prefetch side,
// delivery scoreboard with an independent negedge monitor, plus a short-timeout watchdog instance.
module tb_fetch_port;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_flush, imem_ready;
  logic [31:0] fetch_addr, imem_rdata;
  logic [31:0] fetch_rdata, imem_addr;
  logic        fetch_ready, fetch_error, imem_valid, imem_instr;

  logic        wd_fetch_valid;
  logic [31:0] wd_fetch_rdata, wd_imem_addr;
  logic        wd_fetch_ready, wd_fetch_error, wd_imem_valid, wd_imem_instr;

  always #5 clk = ~clk;

  fetch_port u_dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_valid(fetch_valid),
    .fetch_addr (fetch_addr),
    .fetch_flush(fetch_flush),
    .fetch_rdata(fetch_rdata),
    .fetch_ready(fetch_ready),
    .fetch_error(fetch_error),
    .imem_valid (imem_valid),
    .imem_instr (imem_instr),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata)
  );

  fetch_port #(.timeout_cycles(4), .timeout_width(3)) u_wd (
    .clk        (clk),
    .rst        (rst),
    .fetch_valid(wd_fetch_valid),
    .fetch_addr (32'h0000_0040),
    .fetch_flush(1'b0),
    .fetch_rdata(wd_fetch_rdata),
    .fetch_ready(wd_fetch_ready),
    .fetch_error(wd_fetch_error),
    .imem_valid (wd_imem_valid),
    .imem_instr (wd_imem_instr),
    .imem_addr  (wd_imem_addr),
    .imem_ready (1'b0),
    .imem_rdata (32'h0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C);
  endfunction

  // Stimulus knobs
  int          wait_cfg = 0;
  int          valid_pct = 0;
  int          flush_pct = 0;
  bit          f_now = 1'b0;
  logic [31:0] f_tgt = '0;
  bit          stray_ready = 1'b0;
  bit          wd_go = 1'b0;

  // Reference model state
  logic [31:0] fpc = '0;
  logic [31:0] flush_tgt = '0;
  bit          req_active = 1'b0;
  bit          req_stale = 1'b0;
  logic [31:0] req_addr = '0;
  int          wl = 0;
  bit          last_fv = 1'b0;
  bit          last_ready = 1'b0;
  logic [31:0] last_fa = '0;
  logic [31:0] exp_q[$];
  int          deliveries = 0;

  // One cycle of stimulus: retire/observe requests, then drive prefetch and memory inputs.
  task automatic tick();
    bit          done, done_stale, exp_new, fl;
    logic [31:0] raw;
    @(posedge clk);
    #1;
    if (!rst) begin
      req_active = 1'b0; req_stale = 1'b0; exp_q.delete();
      last_fv = 1'b0; last_ready = 1'b0;
      fetch_valid = 1'b0; fetch_flush = 1'b0; imem_ready = 1'b0; wd_fetch_valid = 1'b0;
      return;
    end
    done = 1'b0; done_stale = 1'b0;
    if (req_active && last_ready) begin
      done = 1'b1; done_stale = req_stale; req_active = 1'b0;
    end
    // A killed request is always replaced by one to the most recent flush target.
    exp_new = !req_active && (last_fv || (done && done_stale));
    chk("imem_valid", 32'(imem_valid), 32'(exp_new || req_active));
    if (exp_new) begin
      req_active = 1'b1;
      req_stale  = 1'b0;
      req_addr   = (done && done_stale) ? flush_tgt : {last_fa[31:2], 2'b00};
      wl         = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
      fpc        = fpc + 32'd4;
    end
    if (req_active) chk("imem_addr", imem_addr, req_addr);

    fl = f_now || ($urandom_range(0, 99) < flush_pct);
    fetch_valid = ($urandom_range(0, 99) < valid_pct);
    if (fl) begin
      raw       = f_now ? f_tgt : ($urandom & 32'h0003_FFFF);
      fpc       = {raw[31:2], 2'b00};
      flush_tgt = fpc;
      fetch_addr = raw;
      if (req_active) req_stale = 1'b1;
    end else if (fetch_valid) begin
      fetch_addr = fpc | 32'($urandom_range(0, 3));
    end else begin
      fetch_addr = $urandom;
    end
    fetch_flush = fl;
    f_now = 1'b0;

    if (req_active && wl == 0) begin
      imem_ready = 1'b1;
      imem_rdata = mem_word(req_addr);
    end else begin
      imem_ready = stray_ready && !req_active;
      imem_rdata = $urandom;
      if (req_active) wl--;
    end
    stray_ready = 1'b0;
    if (imem_ready && req_active && !req_stale) exp_q.push_back(mem_word(req_addr));

    wd_fetch_valid = wd_go;
    wd_go = 1'b0;
    last_fv = fetch_valid; last_fa = fetch_addr; last_ready = imem_ready;
  endtask

  // Delivery monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (rst) begin
      chk("imem_instr", 32'(imem_instr), 32'd1);
      if (fetch_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fetch_ready", 32'(fetch_ready), 32'd0);
        end else begin
          chk("fetch_rdata", fetch_rdata, exp_q.pop_front());
          deliveries++;
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_fetch_ready", 32'(fetch_ready), 32'd1);
        exp_q.delete();
      end else begin
        chk("rdata_nop", fetch_rdata, NOP);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; fetch_valid = 1'b0; fetch_flush = 1'b0; fetch_addr = '0;
    imem_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF; wd_fetch_valid = 1'b0;
    #12;
    chk("rst_imem_valid", 32'(imem_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("rst_fetch_rdata", fetch_rdata, NOP);
    chk("rst_fetch_error", 32'(fetch_error), 32'd0);
    chk("rst_wd_error", 32'(wd_fetch_error), 32'd0);
    @(posedge clk); #3; rst = 1'b1;

    // Zero-wait streaming at one word per cycle
    wait_cfg = 0; valid_pct = 100; fpc = 32'h100;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("stream_addr", imem_addr, 32'h100 + 32'(4 * i));
      chk("stream_ready", 32'(fetch_ready), 32'd1);
    end
    valid_pct = 0;
    repeat (3) tick();

    // Unaligned target is aligned on the bus
    f_now = 1'b1; f_tgt = 32'h202; valid_pct = 100;
    tick();
    valid_pct = 0;
    tick();
    @(negedge clk);
    chk("align_addr", imem_addr, 32'h200);
    repeat (2) tick();

    // Flush alone in IDLE does nothing
    f_now = 1'b1; f_tgt = 32'h40;
    tick(); tick();
    @(negedge clk);
    chk("idle_flush_valid", 32'(imem_valid), 32'd0);

    // Three wait cycles: request stable, word only in the fourth cycle
    wait_cfg = 3; f_now = 1'b1; f_tgt = 32'h40; valid_pct = 100;
    tick();
    valid_pct = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      chk("wait_valid", 32'(imem_valid), 32'd1);
      chk("wait_addr", imem_addr, 32'h40);
      chk("wait_ready", 32'(fetch_ready), 32'(i == 4));
      if (i == 4) chk("wait_rdata", fetch_rdata, 32'hDEAD_BEEF);
    end
    tick();

    // Flush in the second wait cycle kills the response
    f_now = 1'b1; f_tgt = 32'h40; valid_pct = 100;
    tick();
    valid_pct = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin f_now = 1'b1; f_tgt = 32'h800; end
      tick();
      @(negedge clk);
      if (c <= 7) chk("kill_ready", 32'(fetch_ready), 32'd0);
      if (c == 5) chk("kill_reissue_addr", imem_addr, 32'h800);
      if (c == 8) chk("kill_new_rdata", fetch_rdata, mem_word(32'h800));
    end
    tick();

    // Flush coinciding with imem_ready
    wait_cfg = 1; f_now = 1'b1; f_tgt = 32'h40; valid_pct = 100;
    tick();
    valid_pct = 0;
    tick();
    f_now = 1'b1; f_tgt = 32'h900;
    tick();
    @(negedge clk);
    chk("sameflush_ready", 32'(fetch_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("sameflush_addr", imem_addr, 32'h900);
    repeat (3) tick();

    // Two flushes while killing: only the last target is issued
    wait_cfg = 4; f_now = 1'b1; f_tgt = 32'h40; valid_pct = 100;
    tick();
    valid_pct = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) begin f_now = 1'b1; f_tgt = 32'hA00; end
      if (c == 2) begin f_now = 1'b1; f_tgt = 32'hB00; end
      tick();
    end
    @(negedge clk);
    chk("double_kill_addr", imem_addr, 32'hB00);
    repeat (6) tick();

    // Randomized traffic
    wait_cfg = -1; valid_pct = 75; flush_pct = 10;
    repeat (3000) tick();
    valid_pct = 0; flush_pct = 0; wait_cfg = 0;
    repeat (12) tick();
    @(negedge clk);
    chk("random_deliveries_seen", 32'(deliveries > 500), 32'd1);
    chk("main_no_error", 32'(fetch_error), 32'd0);
    chk("drain_idle", 32'(imem_valid), 32'd0);

    // Watchdog on the short-timeout instance; main keeps a long request outstanding
    wait_cfg = 1000; f_now = 1'b1; f_tgt = 32'h40; valid_pct = 100; wd_go = 1'b1;
    tick();
    valid_pct = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      @(negedge clk);
      chk("wd_error_edge", 32'(wd_fetch_error), 32'(k == 5));
    end
    repeat (10) tick();
    @(negedge clk);
    chk("wd_error_sticky", 32'(wd_fetch_error), 32'd1);
    chk("wd_no_retry_valid", 32'(wd_imem_valid), 32'd1);
    chk("wd_no_retry_addr", wd_imem_addr, 32'h40);
    chk("main_pending_valid", 32'(imem_valid), 32'd1);

    // Asynchronous reset mid-request
    @(posedge clk); #3; rst = 1'b0;
    #1;
    chk("async_imem_valid", 32'(imem_valid), 32'd0);
    chk("async_imem_addr", imem_addr, 32'd0);
    chk("async_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("async_fetch_rdata", fetch_rdata, NOP);
    chk("async_wd_error", 32'(wd_fetch_error), 32'd0);
    chk("async_wd_valid", 32'(wd_imem_valid), 32'd0);
    tick(); tick();
    #2; rst = 1'b1;

    // Stray imem_ready while idle is ignored
    wait_cfg = 0;
    stray_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("stray_ready_dropped", 32'(fetch_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("stray_stays_idle", 32'(imem_valid), 32'd0);

    valid_pct = 100; fpc = 32'h300;
    repeat (4) tick();
    valid_pct = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
